// File: rtl/seg_display_decoder_if.sv
// Frame output channel of seg_display_decoder: captured digits plus valid/ready handshake.
// master = decoder (producer), slave = consumer.
interface seg_display_decoder_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   bad_mask;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    output value, dp, bad_mask, frame_valid,
    input  frame_ready
  );

  modport slave (
    input  value, dp, bad_mask, frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seg_display_decoder.sv
// Snoops a multiplexed active-low seven-segment bus, decodes each settled digit to hex and
// offers complete frames on a valid/ready channel. Define SEG_DECODE_DP_EN to capture decimal points.
module seg_display_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [7:0]            seg_n,
  seg_display_decoder_if.master frame,
  output logic                  sync_err,
  output logic                  overrun
);
  localparam int EXP_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
`ifdef SEG_DECODE_DP_EN
  localparam logic [7:0] SEG_USED = 8'hFF;
`else
  // dp line forced to its idle level so it never captures and never counts as a change.
  localparam logic [7:0] SEG_USED = 8'h7F;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, DONE} state_e;

  state_e              state_q, state_d;
  logic [DIGITS-1:0]   an_s1, an_s2, an_p;
  logic [7:0]          seg_s1, seg_s2, seg_p;
  logic [CNT_W-1:0]    cnt_q;
  logic [EXP_W-1:0]    exp_q;
  logic [4*DIGITS-1:0] scr_value;
  logic [DIGITS-1:0]   scr_dp, scr_bad;

  logic [DIGITS-1:0]   an_act, exp_oh, next_oh;
  logic                sel_first, sel_exp, sel_next, all_off, anode_bad;
  logic                changed, last, settled;
  logic                capture, advance, abort;
  logic [4:0]          glyph;

  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'h3F:   decode = {1'b0, 4'h0};
      7'h06:   decode = {1'b0, 4'h1};
      7'h5B:   decode = {1'b0, 4'h2};
      7'h4F:   decode = {1'b0, 4'h3};
      7'h66:   decode = {1'b0, 4'h4};
      7'h6D:   decode = {1'b0, 4'h5};
      7'h7D:   decode = {1'b0, 4'h6};
      7'h07:   decode = {1'b0, 4'h7};
      7'h7F:   decode = {1'b0, 4'h8};
      7'h6F:   decode = {1'b0, 4'h9};
      7'h77:   decode = {1'b0, 4'hA};
      7'h7C:   decode = {1'b0, 4'hB};
      7'h39:   decode = {1'b0, 4'hC};
      7'h3E:   decode = {1'b0, 4'hD};
      7'h79:   decode = {1'b0, 4'hE};
      7'h71:   decode = {1'b0, 4'hF};
      default: decode = {1'b1, 4'h0};
    endcase
  endfunction

  // Input synchronizers plus one extra stage holding the previous sample for change detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1  <= '1;
      an_s2  <= '1;
      an_p   <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
    end else begin
      an_s1  <= an_n;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= seg_n | ~SEG_USED;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  assign an_act    = ~an_s2;
  assign exp_oh    = DIGITS'(1) << exp_q;
  assign next_oh   = exp_oh << 1;
  assign sel_first = (an_act == DIGITS'(1));
  assign sel_exp   = (an_act == exp_oh);
  assign sel_next  = (next_oh != '0) && (an_act == next_oh);
  assign all_off   = (an_act == '0);
  assign anode_bad = !(all_off || sel_exp || sel_next);
  assign changed   = ({an_s2, seg_s2} != {an_p, seg_p});
  assign last      = (exp_q == EXP_W'(DIGITS - 1));
  assign settled   = sel_exp && !changed && (cnt_q == CNT_MAX);
  assign glyph     = decode(~seg_s2[6:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (changed)        cnt_q <= '0;
    else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE:   if (sel_first) state_d = SETTLE;
      SETTLE: begin
        if (anode_bad) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (settled) begin
          capture = 1'b1;
          state_d = last ? DONE : HOLD;
        end
      end
      HOLD: begin
        if (anode_bad) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sel_next) begin
          advance = 1'b1;
          state_d = SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the scratch frame is small register storage, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= '0;
      scr_value <= '0;
      scr_dp    <= '0;
      scr_bad   <= '0;
    end else if (state_q == IDLE) begin
      exp_q     <= '0;
      scr_value <= '0;
      scr_dp    <= '0;
      scr_bad   <= '0;
    end else begin
      if (advance) exp_q <= exp_q + 1'b1;
      if (capture) begin
        scr_value[4*exp_q +: 4] <= glyph[3:0];
        scr_dp[exp_q]           <= ~seg_s2[7];
        scr_bad[exp_q]          <= glyph[4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_err <= 1'b0;
    else        sync_err <= abort;
  end

  // A new frame may load in the same cycle the held one is accepted; otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.value       <= '0;
      frame.dp          <= '0;
      frame.bad_mask    <= '0;
      frame.frame_valid <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      if (frame.frame_valid && frame.frame_ready) begin
        frame.frame_valid <= 1'b0;
        overrun           <= 1'b0;
      end
      if (state_q == DONE) begin
        if (!frame.frame_valid || frame.frame_ready) begin
          frame.value       <= scr_value;
          frame.dp          <= scr_dp;
          frame.bad_mask    <= scr_bad;
          frame.frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_display_decoder.sv
// Self-checking bench for seg_display_decoder: directed scenarios plus random frames,
// checked by a scoreboard fed from a glyph-table reference model.
module tb_seg_display_decoder;
  localparam int DIGITS = 4;
  localparam int STABLE = 8;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h3E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   bad;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIGITS-1:0] an_n;
  logic [7:0]        seg_n;
  logic              sync_err;
  logic              overrun;

  int     checks = 0;
  int     errors = 0;
  int     serr_cnt = 0;
  frame_t sb_q[$];

  seg_display_decoder_if #(.DIGITS(DIGITS)) frame_if ();

  seg_display_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .an_n     (an_n),
    .seg_n    (seg_n),
    .frame    (frame_if.master),
    .sync_err (sync_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: look each pattern up in the glyph table; anything not found is a bad digit.
  function automatic frame_t model(input logic [8*DIGITS-1:0] segs);
    frame_t     f;
    logic [7:0] s;
    logic       hit;
    f = '0;
    for (int d = 0; d < DIGITS; d++) begin
      s   = ~segs[8*d +: 8];
      hit = 1'b0;
      for (int n = 0; n < 16; n++) begin
        if (!hit && s[6:0] == GLYPH[n]) begin
          f.value[4*d +: 4] = 4'(n);
          hit = 1'b1;
        end
      end
      f.bad[d] = !hit;
`ifdef SEG_DECODE_DP_EN
      f.dp[d] = s[7];
`endif
    end
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input int d, input logic [7:0] s, input int hold);
    an_n  = ~(DIGITS'(1) << d);
    seg_n = s;
    tick(hold);
  endtask

  task automatic blank(input int n);
    an_n  = '1;
    seg_n = 8'hFF;
    tick(n);
  endtask

  task automatic scan(input logic [8*DIGITS-1:0] segs, input int hold, input int gap);
    for (int d = 0; d < DIGITS; d++) begin
      show(d, segs[8*d +: 8], hold);
      if (gap > 0) blank(gap);
    end
    blank(6);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_value"},    64'(frame_if.value),       64'd0);
    check({tag, "_dp"},       64'(frame_if.dp),          64'd0);
    check({tag, "_bad"},      64'(frame_if.bad_mask),    64'd0);
    check({tag, "_valid"},    64'(frame_if.frame_valid), 64'd0);
    check({tag, "_sync_err"}, 64'(sync_err),             64'd0);
    check({tag, "_overrun"},  64'(overrun),              64'd0);
  endtask

  // Monitor: every accepted handshake pops one expected frame.
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sync_err) serr_cnt++;
      if (rst_n && frame_if.frame_valid && frame_if.frame_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got value %0h expected no frame", frame_if.value);
        end else begin
          e = sb_q.pop_front();
          check("frame_value", 64'(frame_if.value),    64'(e.value));
          check("frame_dp",    64'(frame_if.dp),       64'(e.dp));
          check("frame_bad",   64'(frame_if.bad_mask), 64'(e.bad));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [8*DIGITS-1:0] segs;
    frame_t              fa, fc;
    logic [6:0]          pat;

    rst_n = 1'b0;
    an_n  = '1;
    seg_n = 8'hFF;
    frame_if.frame_ready = 1'b1;
    tick(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick(2);
    check_zero_outputs("post_reset");

    // Basic scan 1,2,3,4.
    segs = {8'h99, 8'hB0, 8'hA4, 8'hF9};
    check("model_4321", 64'(model(segs).value), 64'h4321);
    sb_q.push_back(model(segs));
    scan(segs, 12, 0);
    wait_drain("drain_basic");

    // Digit 2 shows D with its decimal point lit.
    segs = {8'hF9, 8'h41, 8'hC0, 8'hA4};
    sb_q.push_back(model(segs));
    scan(segs, 12, 2);
    wait_drain("drain_dp");

    // Digit 1 shows an illegal blank pattern.
    segs = {8'h99, 8'hB0, 8'hFF, 8'hF9};
    sb_q.push_back(model(segs));
    scan(segs, 12, 0);
    wait_drain("drain_bad");

    // Digit 1 skipped: abort, then a clean frame.
    show(0, 8'hF9, 12);
    show(2, 8'hB0, 12);
    blank(4);
    check("sync_err_count", 64'(serr_cnt), 64'd1);
    segs = {8'h82, 8'h92, 8'h88, 8'h80};
    sb_q.push_back(model(segs));
    scan(segs, 12, 1);
    wait_drain("drain_after_abort");

    // Digit 1 flashed too briefly as 7, then re-shown long enough as 5.
    segs = {8'h99, 8'hB0, 8'h92, 8'hF9};
    sb_q.push_back(model(segs));
    show(0, 8'hF9, 12);
    show(1, 8'hF8, 5);
    blank(2);
    show(1, 8'h92, 10);
    show(2, 8'hB0, 12);
    show(3, 8'h99, 12);
    blank(6);
    wait_drain("drain_short_hold");

    // Two frames with the consumer stalled: first held, second dropped.
    frame_if.frame_ready = 1'b0;
    segs = {8'hC6, 8'h83, 8'h88, 8'h8E};
    fa = model(segs);
    sb_q.push_back(fa);
    scan(segs, 12, 0);
    scan({8'hF9, 8'hF9, 8'hF9, 8'hF9}, 12, 0);
    check("held_valid",   64'(frame_if.frame_valid), 64'd1);
    check("held_value",   64'(frame_if.value),       64'(fa.value));
    check("overrun_set",  64'(overrun),              64'd1);
    frame_if.frame_ready = 1'b1;
    tick(2);
    check("overrun_clear", 64'(overrun),              64'd0);
    check("valid_clear",   64'(frame_if.frame_valid), 64'd0);
    wait_drain("drain_overrun");

    // Hold a frame, start another, then reset asynchronously mid-frame.
    frame_if.frame_ready = 1'b0;
    segs = {8'h90, 8'h80, 8'hF8, 8'h82};
    fc = model(segs);
    scan(segs, 12, 0);
    check("stall_value", 64'(frame_if.value), 64'(fc.value));
    show(0, 8'hA4, 12);
    show(1, 8'hB0, 6);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    an_n  = '1;
    seg_n = 8'hFF;
    tick(2);
    rst_n = 1'b1;
    frame_if.frame_ready = 1'b1;
    tick(2);

    // Random frames with random holds, gaps and occasional illegal patterns.
    for (int f = 0; f < 24; f++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 5) == 0) pat = 7'($urandom);
        else                           pat = GLYPH[$urandom_range(0, 15)];
        segs[8*d +: 8] = ~{1'($urandom), pat};
      end
      sb_q.push_back(model(segs));
      for (int d = 0; d < DIGITS; d++) begin
        show(d, segs[8*d +: 8], int'($urandom_range(10, 14)));
        blank(int'($urandom_range(0, 3)));
      end
      blank(6);
    end
    wait_drain("drain_random");
    check("sync_err_total", 64'(serr_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_display_decoder.md
# seg_display_decoder

Receive-side counterpart of the team's hex-to-seven-segment encoder. Snoops a time-multiplexed, active-low seven-segment display bus (digit anode enables plus segment lines), waits for each digit's pattern to settle, decodes it back to a 4-bit hex value, and assembles a complete multi-digit frame. Frames are offered on a valid/ready interface. Used as a display-readback checker and as a capture block on lab boards.

## Interface
- `DIGITS`, 4 — digits per frame; range 1..8.
- `STABLE_CYCLES`, 8 — consecutive unchanged synchronized samples required before a digit is captured; minimum 2.
- `clk` in 1 — single clock; all logic rises on `posedge clk`.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `an_n` in DIGITS — digit enables, active-low; bit i low selects digit i.
- `seg_n` in 8 — segment lines, active-low; bit0=a … bit6=g, bit7=dp.
- `value` out 4*DIGITS — captured frame; digit i occupies bits [4i+3:4i].
- `dp` out DIGITS — captured decimal points, active-high.
- `bad_mask` out DIGITS — bit i set when digit i's pattern was not a legal glyph.
- `frame_valid` out 1 — frame available; held until accepted.
- `frame_ready` in 1 — consumer accepts the frame when `frame_valid` and `frame_ready` are both high.
- `sync_err` out 1 — one-cycle pulse when a frame is aborted.
- `overrun` out 1 — sticky; set when a completed frame is dropped.

## Operation
- Input stage: 2-flop synchronizer on `an_n` and `seg_n`. All decode logic uses the synchronized copies only.
- Glyph table, active-high in gfedcba order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, B=7C, C=39, D=3E, E=79, F=71
  - Any other pattern decodes to nibble 0 and sets that digit's `bad_mask` bit.
- Settle counter: clears whenever the synchronized {an_n, seg_n} differs from the previous sample; otherwise increments, saturating at STABLE_CYCLES-1.
- Expected-digit index `exp` runs 0..DIGITS-1.
- State machine:
  - IDLE: clear `exp` and the frame scratch registers. Go to SETTLE when the synchronized anode is one-hot selecting digit 0.
  - SETTLE: when the counter reaches STABLE_CYCLES-1 with digit `exp` selected, capture nibble, dp and bad bit into slot `exp`, then go to HOLD.
  - HOLD: wait for the anode to leave digit `exp`. All-anodes-off (blanking) is allowed. When digit `exp+1` is selected, increment `exp` and return to SETTLE.
  - Last digit: when `exp`=DIGITS-1 is captured, the frame is complete. Go to DONE for one cycle, then IDLE.
- Abort rule: in SETTLE or HOLD, a non-one-hot anode pattern other than all-off, or a one-hot anode that is neither `exp` nor `exp+1`, discards the scratch frame, pulses `sync_err`, and returns to IDLE.
- Output register, in DONE:
  - If `frame_valid`=0, or `frame_valid` and `frame_ready` are both high in that cycle: load `value`/`dp`/`bad_mask` and assert `frame_valid`.
  - Otherwise: drop the new frame and set `overrun`.
- `overrun` clears on the next accepted handshake.
- `frame_valid` deasserts on handshake unless a new frame loads in the same cycle.

## Timing
- Reset values: `value`=0, `dp`=0, `bad_mask`=0, `frame_valid`=0, `sync_err`=0, `overrun`=0. State=IDLE, counter=0, synchronizers all-ones (idle bus).
- Input-to-internal latency: 2 cycles.
- Capture: STABLE_CYCLES cycles after the last synchronized change of a selected digit.
- `frame_valid` rises the cycle after DONE, i.e. 2 cycles after the last digit's capture edge.
- `sync_err` pulse: the cycle after the offending sample.
- `rst_n` low mid-frame: immediate asynchronous return to reset values; any partial frame is lost.
- A digit held for fewer than STABLE_CYCLES samples is never captured. The frame stalls in SETTLE until the digit is re-shown long enough or an abort occurs.

## Configuration
- `SEG_DECODE_DP_EN` defined: `seg_n[7]` is captured into `dp`.
- Not defined: `seg_n[7]` is ignored, excluded from change detection, and `dp` is tied to 0.

## Test plan
- Scan 1,2,3,4 (seg_n ~06, ~5B, ~4F, ~66), each digit held 12 cycles, `frame_ready`=1 → `value`=16'h4321, `bad_mask`=0, `frame_valid` high for 1 cycle.
- Digit 2 shows ~3E with dp low, under `SEG_DECODE_DP_EN` → nibble D, `dp`=4'b0100. Without the macro → `dp`=0.
- Digit 1 shows illegal pattern 7'h00 → `value[7:4]`=0, `bad_mask`=4'b0010.
- Order 0,2 (digit 1 skipped) → `sync_err` pulses once, no `frame_valid`, the next clean frame decodes correctly.
- Digit held only 5 cycles with STABLE_CYCLES=8 → no capture. The same digit re-shown for 10 cycles → captured.
- `frame_ready`=0 for two frames → first frame held, `overrun`=1. Raise `frame_ready` → handshake completes, `overrun`=0. Assert `rst_n` low mid-frame → all outputs 0 asynchronously.
